vga_timing_generator: RTL
=========================

// Module: vga_timing_generator
// PURPOSE
//  Source end of the pixel-coordinate interface consumed by the VGA visualizers. Runs in the
//  pixel_clk domain and produces raster counters, HS/VS, blanking, and the per-frame swap tick.
//  Drives the DAC sync pins and the visualizers' pixel_x/pixel_y/video_on/i_frame_over inputs.
// PARAMETERS
//  H_ACTIVE 640  visible pixels per line        | H_FP 16  H_SYNC 96  H_BP 48  (H_TOTAL=800)
//  V_ACTIVE 480  visible lines per frame        | V_FP 10  V_SYNC 2   V_BP 33  (V_TOTAL=525)
//  HS_POL   0    HS active level (0 = active-low)
//  VS_POL   0    VS active level (0 = active-low)
//  CNT_W    10   counter width; H_TOTAL and V_TOTAL must each be <= 2**CNT_W
// PORTS
//  pixel_clk     in   1      pixel clock, 25.175 MHz nominal
//  rst_n         in   1      asynchronous active-low reset
//  o_hsync       out  1      horizontal sync, polarity set by HS_POL
//  o_vsync       out  1      vertical sync, polarity set by VS_POL
//  o_blank_n     out  1      DAC blank; equals video_on
//  o_sync_n      out  1      DAC composite sync; tied to 0
//  pixel_x       out  CNT_W  horizontal count 0..H_TOTAL-1
//  pixel_y       out  CNT_W  vertical count 0..V_TOTAL-1
//  video_on      out  1      1 iff pixel_x<H_ACTIVE && pixel_y<V_ACTIVE
//  o_frame_over  out  1      single-cycle tick at the start of vertical blanking
//  o_line_start  out  1      single-cycle tick when pixel_x==0
// BEHAVIOUR
//  - Every output is registered. All outputs in a given cycle describe the same pixel
//    (pixel_x, pixel_y); there is no skew between sync signals and coordinates.
//  - h_cnt increments every cycle. When h_cnt reaches H_TOTAL-1, it wraps to 0 and v_cnt advances.
//    When v_cnt wraps from V_TOTAL-1, it returns to 0. One frame is exactly H_TOTAL*V_TOTAL cycles.
//  - HS is active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
//  - VS is active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults).
//    VS is a function of v only, so it changes together with the line wrap.
//  - o_frame_over is high only at (pixel_x==0, pixel_y==V_ACTIVE): one pulse per frame.
//    A display-bank swap at this point cannot tear.
//  - o_line_start is high at pixel_x==0 on every line, including blanking lines.
//  - Reset (asynchronous assert):
//      h_cnt=v_cnt=0, pixel_x=pixel_y=0, video_on=0, o_blank_n=0, o_frame_over=0,
//      o_line_start=0, o_hsync=~HS_POL, o_vsync=~VS_POL (both inactive).
//  - Reset release: the first pixel_clk edge presents pixel (0,0) with video_on=1 and
//    o_line_start=1. The frame then proceeds normally.
//  - Reset asserted mid-frame: all outputs return to reset values immediately, with no partial
//    sync pulse held. After release, the raster restarts at (0,0).
//    The first o_frame_over after release occurs H_TOTAL*V_ACTIVE cycles later.
//  - Counter and compare arithmetic is unsigned CNT_W bits. Sync window bounds are computed as
//    localparams. No counter value >= H_TOTAL or V_TOTAL is ever presented.
// STRUCTURE
//  - Shared header vga_timing_defs.vh holds the 640x480@60 localparams (active, porches,
//    sync widths, totals, polarities) used by this block and by the visualizers (SCREEN_W, SCREEN_H).
//  - One sub-module, vga_axis_counter (params ACTIVE, FP, SYNC, BP, POL; ports pixel_clk, rst_n,
//    i_step, o_cnt, o_wrap, o_active, o_sync), is instantiated twice:
//      H axis with i_step=1; V axis with i_step=H o_wrap.
//    The top level registers the combined outputs and decodes the frame_over and line_start ticks.
// TESTING
//  1. Reset, then release -> outputs hold reset values while rst_n=0. The cycle after release
//     shows pixel=(0,0), video_on=1, o_line_start=1.
//  2. Run one full line -> o_hsync low for exactly 96 cycles starting at pixel_x=656.
//     video_on is 1 for exactly 640 cycles. pixel_x wraps 799->0 and pixel_y increments.
//  3. Run 2 frames -> o_frame_over pulses exactly twice, 420000 cycles apart, each at (0,480).
//     o_vsync is low only on lines 490-491 (1600 cycles per frame).
//  4. Assert rst_n at (300,200) for 3 cycles -> outputs go to reset values immediately.
//     After release the raster restarts at (0,0), and the next o_frame_over comes 384000 cycles later.
//  5. Override parameters H 4/1/2/1, V 3/1/1/1, HS_POL=1 -> full-frame scoreboard of
//     hsync/vsync/video_on against a reference model for every cycle of 3 frames.
//  6. Counter bounds check -> assertions that pixel_x<H_TOTAL, pixel_y<V_TOTAL, and
//     o_blank_n==video_on hold on every cycle.

Source files
------------

// File: rtl/vga_timing_generator_pkg.sv
// Shared 640x480@60 raster constants for the timing generator and the visualizers.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package vga_timing_generator_pkg;

   // Horizontal timing, in pixel clocks
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;

   // Vertical timing, in lines
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   // Sync polarities: 0 means the pulse is driven low
   localparam logic VGA_HS_POL = 1'b0;
   localparam logic VGA_VS_POL = 1'b0;

   localparam int VGA_CNT_W = 10;

   // Visible area as seen by the visualizers
   localparam int SCREEN_W = VGA_H_ACTIVE;
   localparam int SCREEN_H = VGA_V_ACTIVE;

   // Period of one axis: visible region plus the three blanking segments
   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int VGA_H_TOTAL = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
   localparam int VGA_V_TOTAL = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus combinational active/sync window decode.
// Latency: o_cnt is the registered count; o_wrap/o_active/o_sync decode it in the same cycle.
// Backpressure: none; advances on every cycle where i_step is high.
//
// Ports:
//   pixel_clk  pixel clock
//   rst_n      asynchronous active-low reset, clears the count
//   i_step     advance enable (1 for the H axis, H wrap for the V axis)
//   o_cnt      current position, 0..TOTAL-1
//   o_wrap     high when stepping from TOTAL-1 back to 0 this cycle
//   o_active   position lies in the visible region
//   o_sync     sync level for this position, already at polarity POL
module vga_axis_counter
   import vga_timing_generator_pkg::*;
#(
   parameter int   ACTIVE = VGA_H_ACTIVE,
   parameter int   FP     = VGA_H_FP,
   parameter int   SYNC   = VGA_H_SYNC,
   parameter int   BP     = VGA_H_BP,
   parameter logic POL    = VGA_HS_POL,
   parameter int   CNT_W  = VGA_CNT_W
) (
   input  logic             pixel_clk,
   input  logic             rst_n,
   input  logic             i_step,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_wrap,
   output logic             o_active,
   output logic             o_sync
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

   // Window bounds carry one extra bit so a bound equal to 2**CNT_W does not alias to 0
   localparam logic [CNT_W:0] ACT_END  = (CNT_W+1)'(ACTIVE);
   localparam logic [CNT_W:0] SYNC_BEG = (CNT_W+1)'(ACTIVE + FP);
   localparam logic [CNT_W:0] SYNC_END = (CNT_W+1)'(ACTIVE + FP + SYNC);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   cnt_x;
   logic             at_last;
   logic             in_sync;

   assign cnt_x   = {1'b0, cnt};
   assign at_last = (cnt == LAST);

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (i_step) begin
         cnt <= at_last ? '0 : cnt + 1'b1;
      end
   end

   assign in_sync  = (cnt_x >= SYNC_BEG) && (cnt_x < SYNC_END);

   assign o_cnt    = cnt;
   assign o_wrap   = i_step && at_last;
   assign o_active = (cnt_x < ACT_END);
   assign o_sync   = in_sync ? POL : ~POL;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing source: pixel coordinates, HS/VS, blanking and per-frame/per-line ticks.
// Latency: every output registered; all outputs in a cycle describe the same pixel (no skew).
// Backpressure: none; free-running at one pixel per pixel_clk.
//
// Ports:
//   pixel_clk     pixel clock (25.175 MHz nominal)
//   rst_n         asynchronous active-low reset
//   o_hsync       horizontal sync, active level HS_POL
//   o_vsync       vertical sync, active level VS_POL
//   o_blank_n     DAC blank, same as video_on
//   o_sync_n      DAC composite sync, tied low
//   pixel_x       horizontal position 0..H_TOTAL-1
//   pixel_y       vertical position 0..V_TOTAL-1
//   video_on      pixel lies in the visible area
//   o_frame_over  one-cycle tick at (0, V_ACTIVE), the start of vertical blanking
//   o_line_start  one-cycle tick at pixel_x == 0 on every line
module vga_timing_generator
   import vga_timing_generator_pkg::*;
#(
   parameter int   H_ACTIVE = VGA_H_ACTIVE,
   parameter int   H_FP     = VGA_H_FP,
   parameter int   H_SYNC   = VGA_H_SYNC,
   parameter int   H_BP     = VGA_H_BP,
   parameter int   V_ACTIVE = VGA_V_ACTIVE,
   parameter int   V_FP     = VGA_V_FP,
   parameter int   V_SYNC   = VGA_V_SYNC,
   parameter int   V_BP     = VGA_V_BP,
   parameter logic HS_POL   = VGA_HS_POL,
   parameter logic VS_POL   = VGA_VS_POL,
   parameter int   CNT_W    = VGA_CNT_W
) (
   input  logic             pixel_clk,
   input  logic             rst_n,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_blank_n,
   output logic             o_sync_n,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             video_on,
   output logic             o_frame_over,
   output logic             o_line_start
);

   localparam logic [CNT_W-1:0] V_BLANK_LINE = CNT_W'(V_ACTIVE);

   // The axis counters hold the pixel that will be presented on the next edge; the output
   // registers below present it. This keeps every output aligned to the same pixel and
   // makes the first edge after reset show (0,0).
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_wrap;
   logic             h_active;
   logic             v_active;
   logic             h_sync;
   logic             v_sync;

   // Frame boundaries are decoded from v_cnt directly, so the V wrap is not consumed
   logic             unused_v_wrap;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HS_POL),
      .CNT_W  (CNT_W)
   ) u_h_axis (
      .pixel_clk (pixel_clk),
      .rst_n     (rst_n),
      .i_step    (1'b1),
      .o_cnt     (h_cnt),
      .o_wrap    (h_wrap),
      .o_active  (h_active),
      .o_sync    (h_sync)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VS_POL),
      .CNT_W  (CNT_W)
   ) u_v_axis (
      .pixel_clk (pixel_clk),
      .rst_n     (rst_n),
      .i_step    (h_wrap),
      .o_cnt     (v_cnt),
      .o_wrap    (unused_v_wrap),
      .o_active  (v_active),
      .o_sync    (v_sync)
   );

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_x      <= '0;
         pixel_y      <= '0;
         video_on     <= 1'b0;
         o_blank_n    <= 1'b0;
         o_hsync      <= ~HS_POL;
         o_vsync      <= ~VS_POL;
         o_frame_over <= 1'b0;
         o_line_start <= 1'b0;
      end else begin
         pixel_x      <= h_cnt;
         pixel_y      <= v_cnt;
         video_on     <= h_active && v_active;
         o_blank_n    <= h_active && v_active;
         o_hsync      <= h_sync;
         o_vsync      <= v_sync;
         // First pixel of the first blanking line: bank swaps here cannot tear
         o_frame_over <= (h_cnt == '0) && (v_cnt == V_BLANK_LINE);
         o_line_start <= (h_cnt == '0);
      end
   end

   assign o_sync_n = 1'b0;

endmodule
